ripple_borrow_down_counter: RTL

RIPPLE_BORROW_DOWN_COUNTER -- requirements
Module: RippleBorrowDownCounter

---
 rtl/ripple_borrow_down_counter_pkg.sv | 18 +
 rtl/ripple_borrow_down_counter_decrementer.sv | 32 +++
 rtl/ripple_borrow_down_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/ripple_borrow_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ripple_borrow_down_counter_pkg
// Brief    : Shared state encoding and default width for the down counter.
// Revision : 1.0
// ============================================================================
package ripple_borrow_down_counter_pkg;

  localparam int DEFAULT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : ripple_borrow_down_counter_pkg
`default_nettype wire

// File: rtl/ripple_borrow_down_counter_decrementer.sv
`default_nettype none
// ============================================================================
// Module   : ripple_borrow_down_counter_decrementer
// Brief    : Combinational subtract-one built from a ripple-borrow chain.
// Revision : 1.0
// ============================================================================
module ripple_borrow_down_counter_decrementer
  import ripple_borrow_down_counter_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] data_out,
  output logic            b_out
);

  // w_borrow[0] is the constant "minus one"; w_borrow[BITS] leaves the MSB.
  logic [BITS:0] w_borrow;

  assign w_borrow[0] = 1'b1;

  generate
    for (genvar i = 0; i < BITS; i++) begin : g_half_sub
      assign data_out[i]   = data_in[i] ^ w_borrow[i];
      assign w_borrow[i+1] = ~data_in[i] & w_borrow[i];
    end
  endgenerate

  assign b_out = w_borrow[BITS];

endmodule : ripple_borrow_down_counter_decrementer
`default_nettype wire

// File: rtl/ripple_borrow_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : ripple_borrow_down_counter
// Brief    : Loadable wrapping down counter with a one-shot countdown FSM.
// Revision : 1.0
// ============================================================================
module ripple_borrow_down_counter
  import ripple_borrow_down_counter_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            ld,
  input  logic            dec,
  input  logic            start,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] data_out,
  output logic            b_out,
  output logic            zero,
  output logic            busy,
  output logic            done
);

  state_t          r_state;
  logic [BITS-1:0] r_value;
  logic            r_borrow;
  logic [BITS-1:0] w_dec_value;
  logic            w_dec_borrow;

  // One decrementer feeds both the manual dec path and the countdown.
  ripple_borrow_down_counter_decrementer #(
    .BITS (BITS)
  ) u_decrementer (
    .data_in  (r_value),
    .data_out (w_dec_value),
    .b_out    (w_dec_borrow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value  <= '0;
      r_borrow <= 1'b0;
      r_state  <= IDLE;
    end else if (clr) begin
      r_value  <= '0;
      r_borrow <= 1'b0;
      r_state  <= IDLE;
    end else if (ld) begin
      r_value  <= data_in;
      r_borrow <= 1'b0;
      r_state  <= IDLE;
    end else begin
      case (r_state)
        RUN: begin
          // RUN is only entered with a nonzero value, so this never wraps.
          r_value <= w_dec_value;
          r_state <= (w_dec_value == '0) ? DONE : RUN;
        end
        IDLE, DONE: begin
          if (start) begin
            r_value  <= data_in;
            r_borrow <= 1'b0;
            r_state  <= (data_in != '0) ? RUN : DONE;
          end else if (dec) begin
            r_value  <= w_dec_value;
            r_borrow <= w_dec_borrow;
            r_state  <= IDLE;
          end else begin
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out = r_value;
  assign b_out    = r_borrow;
  assign zero     = (r_value == '0);
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule : ripple_borrow_down_counter
`default_nettype wire
